// File: rtl/pcw_pkg.sv
// Shared constants for the PCW system-tick timer: port F4 bit layout,
// default tick divider and tick-counter geometry.
package pcw_pkg;

  localparam int F4_CNT_LSB = 0;
  localparam int F4_CNT_MSB = 3;
  localparam int F4_OVF     = 4;
  localparam int F4_INTEN   = 6;
  localparam int F4_FDC     = 7;

  localparam int TIMER_DIVIDER_DEFAULT = 3333;

  localparam int                    TICK_CNT_W   = 4;
  localparam logic [TICK_CNT_W-1:0] TICK_CNT_MAX = 4'hF;

endpackage

// File: rtl/pcw_prescaler.sv
// Divides a clock enable: emits a one-cycle pulse on every DIVIDER-th
// asserted ce_in, coincident with that enable.
module pcw_prescaler
  import pcw_pkg::*;
#(
  parameter int DIVIDER = TIMER_DIVIDER_DEFAULT,
  parameter int CNT_W   = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic ce_in,
  output logic pulse
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDER - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Advance on enables only; wrap at LAST and fire the pulse in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    pulse = 1'b0;
    if (ce_in) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        pulse = ~reset;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Prescaler state register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pcw_timer_irq.sv
// PCW 300 Hz system tick: counts prescaled ticks into a saturating 4-bit
// counter that the CPU reads and clears through port F4, and holds the Z80
// INT line low while unread ticks are pending and interrupts are enabled.
module pcw_timer_irq
  import pcw_pkg::*;
#(
  parameter int DIVIDER = TIMER_DIVIDER_DEFAULT,
  parameter int CNT_W   = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_1mhz,
  input  logic       port_rd,
  input  logic       int_enable,
  input  logic       fdc_int,
  output logic [7:0] rd_data,
  output logic       tick,
  output logic       int_n
);

  logic                  port_rd_q, port_rd_d;
  logic [TICK_CNT_W-1:0] tick_count_q, tick_count_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            rd_data_q, rd_data_d;
  logic                  int_n_q, int_n_d;
  logic                  rd_evt;

  // Saturating increment: the counter sticks at its maximum.
  function automatic logic [TICK_CNT_W-1:0] sat_inc(input logic [TICK_CNT_W-1:0] c);
    if (c == TICK_CNT_MAX) return c;
    return c + TICK_CNT_W'(1);
  endfunction

  pcw_prescaler #(
    .DIVIDER(DIVIDER),
    .CNT_W  (CNT_W)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .ce_in(ce_1mhz),
    .pulse(tick)
  );

  // Read edge detect, tick accounting, status snapshot and interrupt level.
  always_comb begin
    port_rd_d    = port_rd;
    rd_evt       = port_rd & ~port_rd_q;
    tick_count_d = tick_count_q;
    ovf_d        = ovf_q;
    rd_data_d    = rd_data_q;

    if (rd_evt) begin
      rd_data_d                        = '0;
      rd_data_d[F4_CNT_MSB:F4_CNT_LSB] = tick_count_q;
      rd_data_d[F4_OVF]                = ovf_q;
      rd_data_d[F4_INTEN]              = int_enable;
      rd_data_d[F4_FDC]                = fdc_int;
      // A tick landing on the clearing read is not lost: it becomes the first count.
      tick_count_d = tick ? TICK_CNT_W'(1) : '0;
      ovf_d        = 1'b0;
    end else if (tick) begin
      tick_count_d = sat_inc(tick_count_q);
      if (tick_count_q == TICK_CNT_MAX) ovf_d = 1'b1;
    end

    int_n_d = ~(int_enable & (tick_count_d != '0));
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      port_rd_q    <= 1'b0;
      tick_count_q <= '0;
      ovf_q        <= 1'b0;
      rd_data_q    <= 8'h00;
      int_n_q      <= 1'b1;
    end else begin
      port_rd_q    <= port_rd_d;
      tick_count_q <= tick_count_d;
      ovf_q        <= ovf_d;
      rd_data_q    <= rd_data_d;
      int_n_q      <= int_n_d;
    end
  end

  assign rd_data = rd_data_q;
  assign int_n   = int_n_q;

endmodule

// File: tb/tb_pcw_timer_irq.sv
// Bench for pcw_timer_irq: directed scenarios plus randomized traffic checked
// against a behavioural model of tick accounting and the F4 status port.
module tb_pcw_timer_irq;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       ce_i = 1'b0;
  logic       rd_i = 1'b0;
  logic       en_i = 1'b0;
  logic       fdc_i = 1'b0;
  logic [7:0] rd_data;
  logic       tick;
  logic       int_n;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int         ce_total = 0;
  int         pend     = 0;
  bit         ovf_m    = 0;
  bit         prev_rd  = 0;
  logic [7:0] rd_m     = 8'h00;
  logic       intn_m   = 1'b1;
  logic       exp_tick = 1'b0;

  pcw_timer_irq #(.DIVIDER(DIV), .CNT_W(3)) dut (
    .clk       (clk),
    .reset     (rst_i),
    .ce_1mhz   (ce_i),
    .port_rd   (rd_i),
    .int_enable(en_i),
    .fdc_int   (fdc_i),
    .rd_data   (rd_data),
    .tick      (tick),
    .int_n     (int_n)
  );

  always #5 clk = ~clk;

  // Drive inputs mid-cycle and predict this cycle's tick.
  task automatic set_in(input logic ce, input logic rd, input logic en,
                        input logic fdc, input logic rst);
    @(negedge clk);
    ce_i = ce; rd_i = rd; en_i = en; fdc_i = fdc; rst_i = rst;
    #1;
    exp_tick = (!rst && ce && ((ce_total + 1) % DIV == 0)) ? 1'b1 : 1'b0;
  endtask

  // Clock edge; model absorbs the cycle's inputs.
  task automatic advance();
    bit evt;
    @(posedge clk);
    #1;
    if (rst_i) begin
      ce_total = 0; pend = 0; ovf_m = 0; prev_rd = 0; rd_m = 8'h00; intn_m = 1'b1;
    end else begin
      if (ce_i) ce_total++;
      evt = rd_i && !prev_rd;
      prev_rd = rd_i;
      if (evt) begin
        rd_m  = {fdc_i, en_i, 1'b0, ovf_m, 4'(pend)};
        pend  = exp_tick ? 1 : 0;
        ovf_m = 0;
      end else if (exp_tick) begin
        if (pend == 15) ovf_m = 1;
        else pend++;
      end
      intn_m = !(en_i && pend != 0);
    end
  endtask

  task automatic gen_ticks(input int n, input logic en);
    int cnt = 0;
    for (int k = 0; k < n * DIV + DIV && cnt < n; k++) begin
      set_in(1'b1, 1'b0, en, 1'b0, 1'b0);
      if (exp_tick) cnt++;
      advance();
    end
  endtask

  task automatic do_read(input logic en, input logic fdc, input int hold);
    for (int k = 0; k < hold; k++) begin
      set_in(1'b0, 1'b1, en, fdc, 1'b0);
      advance();
    end
    set_in(1'b0, 1'b0, en, fdc, 1'b0);
    advance();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", tick); end
      advance();
      checks++;
      if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
      checks++;
      if (int_n !== 1'b1) begin errors++; $display("FAIL reset_int_n got %b exp 1", int_n); end
    end
    for (int k = 0; k < 5; k++) begin
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (tick !== 1'b0) begin errors++; $display("FAIL idle_tick got %b exp 0", tick); end
      advance();
    end
  endtask

  task automatic test_tick_rate();
    int last = -1;
    bit first = 1;
    for (int i = 0; i < 64; i++) begin
      set_in((i % 4) == 0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (tick !== exp_tick) begin errors++; $display("FAIL tick_rate cyc %0d got %b exp %b", i, tick, exp_tick); end
      if (tick === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (i - last != 16) begin errors++; $display("FAIL tick_spacing got %0d exp 16", i - last); end
        end
        last = i;
      end
      advance();
      if (exp_tick && first) begin
        first = 0;
        checks++;
        if (int_n !== 1'b0) begin errors++; $display("FAIL first_tick_int_n got %b exp 0", int_n); end
      end
    end
    checks++;
    if (last != 60) begin errors++; $display("FAIL last_tick_cycle got %0d exp 60", last); end
    do_read(1'b1, 1'b0, 1);
    checks++;
    if (rd_data !== 8'h44) begin errors++; $display("FAIL tick_rate_read got %h exp 44", rd_data); end
  endtask

  task automatic test_read_clear();
    int seen = 0;
    gen_ticks(3, 1'b1);
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    advance();
    checks++;
    if (rd_data !== 8'h43) begin errors++; $display("FAIL read_clear_data got %h exp 43", rd_data); end
    checks++;
    if (int_n !== 1'b1) begin errors++; $display("FAIL read_clear_int_n got %b exp 1", int_n); end
    for (int k = 0; k < 9; k++) begin
      set_in(seen == 0, 1'b1, 1'b1, 1'b0, 1'b0);
      if (exp_tick) seen++;
      advance();
    end
    checks++;
    if (seen != 1) begin errors++; $display("FAIL held_read_tick got %0d exp 1", seen); end
    checks++;
    if (rd_data !== 8'h43) begin errors++; $display("FAIL held_read_data got %h exp 43", rd_data); end
    checks++;
    if (int_n !== 1'b0) begin errors++; $display("FAIL held_read_int_n got %b exp 0", int_n); end
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    advance();
    do_read(1'b1, 1'b0, 1);
    checks++;
    if (rd_data !== 8'h41) begin errors++; $display("FAIL second_read got %h exp 41", rd_data); end
  endtask

  task automatic test_saturation();
    gen_ticks(17, 1'b1);
    do_read(1'b1, 1'b0, 1);
    checks++;
    if (rd_data !== 8'h5F) begin errors++; $display("FAIL saturate_read got %h exp 5f", rd_data); end
    do_read(1'b1, 1'b0, 1);
    checks++;
    if (rd_data !== 8'h40) begin errors++; $display("FAIL after_ovf_read got %h exp 40", rd_data); end
  endtask

  task automatic test_simultaneous();
    gen_ticks(2, 1'b1);
    for (int k = 0; k < DIV - 1; k++) begin
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      advance();
    end
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (tick !== 1'b1) begin errors++; $display("FAIL simul_tick got %b exp 1", tick); end
    advance();
    checks++;
    if (rd_data[3:0] !== 4'd2) begin errors++; $display("FAIL simul_count got %h exp 2", rd_data[3:0]); end
    checks++;
    if (int_n !== 1'b0) begin errors++; $display("FAIL simul_int_n got %b exp 0", int_n); end
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    advance();
    do_read(1'b1, 1'b0, 2);
    checks++;
    if (rd_data !== 8'h41) begin errors++; $display("FAIL simul_followup got %h exp 41", rd_data); end
  endtask

  task automatic test_mask_fdc();
    gen_ticks(5, 1'b1);
    checks++;
    if (int_n !== 1'b0) begin errors++; $display("FAIL mask_pre_int_n got %b exp 0", int_n); end
    for (int k = 0; k < 3; k++) begin
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      advance();
      checks++;
      if (int_n !== 1'b1) begin errors++; $display("FAIL masked_int_n got %b exp 1", int_n); end
    end
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    advance();
    checks++;
    if (int_n !== 1'b0) begin errors++; $display("FAIL unmask_int_n got %b exp 0", int_n); end
    do_read(1'b1, 1'b1, 1);
    checks++;
    if (rd_data !== 8'hC5) begin errors++; $display("FAIL fdc_read got %h exp c5", rd_data); end
  endtask

  task automatic test_random();
    logic rd = 1'b0;
    logic en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (rd) rd = ($urandom_range(0, 3) != 0);
      else    rd = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 49) == 0) en = ~en;
      set_in(1'($urandom_range(0, 1)), rd, en, 1'($urandom_range(0, 1)),
             $urandom_range(0, 399) == 0);
      checks++;
      if (tick !== exp_tick) begin errors++; $display("FAIL rand_tick cyc %0d got %b exp %b", i, tick, exp_tick); end
      advance();
      checks++;
      if (rd_data !== rd_m) begin errors++; $display("FAIL rand_rd_data cyc %0d got %h exp %h", i, rd_data, rd_m); end
      checks++;
      if (int_n !== intn_m) begin errors++; $display("FAIL rand_int_n cyc %0d got %b exp %b", i, int_n, intn_m); end
    end
  endtask

  initial begin
    test_reset();
    test_tick_rate();
    test_read_clear();
    test_saturation();
    test_simultaneous();
    test_mask_fdc();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
